stack_cmd_ctrl: RTL and testbench

Command front-end that sits directly upstream of the LIFO `stack` block. It accepts stack operations over a valid/ready command channel and sequences the stack's single-cycle `push`/`pop` strobes, including multi-cycle CLEAR and REPLACE-on-full. It checks overflow and underflow, and returns one response per command (status plus data) over a valid/ready response channel.

---
 rtl/stack_pkg.sv | 28 ++
 rtl/stack.sv | 49 ++++
 rtl/stack_cmd_ctrl.sv | 156 +++++++++++++++
 tb/tb_stack_cmd_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types for the stack command controller: opcodes, response status and FSM states.
package stack_pkg;

  typedef enum logic [2:0] {
    OpPush    = 3'd0,
    OpPop     = 3'd1,
    OpPeek    = 3'd2,
    OpReplace = 3'd3,
    OpClear   = 3'd4
  } stack_op_e;

  typedef enum logic [1:0] {
    StatusOk        = 2'd0,
    StatusOverflow  = 2'd1,
    StatusUnderflow = 2'd2,
    StatusIllegal   = 2'd3
  } stack_status_e;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StRepPop,
    StRepPush,
    StClear,
    StResp
  } ctrl_state_e;

endpackage

// File: rtl/stack.sv
// LIFO storage driven by single-cycle push/pop strobes; push+pop together replaces the top.
module stack #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full
);

  localparam int unsigned PtrW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       cnt_q;
  logic [IdxW-1:0]       top_idx;
  logic [IdxW-1:0]       wr_idx;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == PtrW'(DEPTH));
  assign top_idx  = IdxW'(cnt_q - PtrW'(1));
  assign wr_idx   = IdxW'(cnt_q);
  assign data_out = empty ? '0 : mem_q[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (push && !pop && !full) begin
      cnt_q <= cnt_q + PtrW'(1);
    end else if (pop && !push && !empty) begin
      cnt_q <= cnt_q - PtrW'(1);
    end
  end

  // Simultaneous strobes are honoured only when neither empty nor full.
  always_ff @(posedge clk) begin
    if (push && pop && !empty && !full) begin
      mem_q[top_idx] <= data_in;
    end else if (push && !pop && !full) begin
      mem_q[wr_idx] <= data_in;
    end
  end

endmodule

// File: rtl/stack_cmd_ctrl.sv
// Command front-end for the LIFO stack: sequences push/pop strobes and returns one response
// (status + data) per accepted command.
module stack_cmd_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_status,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [DATA_WIDTH-1:0] stk_data_in,
  input  logic [DATA_WIDTH-1:0] stk_data_out,
  input  logic                  stk_empty,
  input  logic                  stk_full
);

  ctrl_state_e           state_q;
  stack_op_e             op_q;
  logic [DATA_WIDTH-1:0] operand_q;
  logic                  cmd_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  stack_status_e         rsp_status_q;
  logic [CNT_WIDTH-1:0]  clr_cnt_q;

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_status  = rsp_status_q;
  assign stk_data_in = operand_q;

  // Strobes are decoded from the state register and the stack flags of the same cycle.
  always_comb begin
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    unique case (state_q)
      StExec: begin
        case (op_q)
          OpPush:    stk_push = !stk_full;
          OpPop:     stk_pop  = !stk_empty;
          OpReplace: begin
            stk_push = !stk_empty && !stk_full;
            stk_pop  = !stk_empty && !stk_full;
          end
          default: ;
        endcase
      end
      StRepPop:  stk_pop  = 1'b1;
      StRepPush: stk_push = 1'b1;
      StClear:   stk_pop  = !stk_empty;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      op_q         <= OpPush;
      operand_q    <= '0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= StatusOk;
      clr_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_q        <= stack_op_e'(cmd_op);
            operand_q   <= cmd_data;
            cmd_ready_q <= 1'b0;
            state_q     <= StExec;
          end
        end
        StExec: begin
          state_q     <= StResp;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= '0;
          case (op_q)
            OpPush: begin
              if (stk_full) begin
                rsp_status_q <= StatusOverflow;
              end else begin
                rsp_status_q <= StatusOk;
                rsp_data_q   <= operand_q;
              end
            end
            OpPop, OpPeek: begin
              if (stk_empty) begin
                rsp_status_q <= StatusUnderflow;
              end else begin
                rsp_status_q <= StatusOk;
                rsp_data_q   <= stk_data_out;
              end
            end
            OpReplace: begin
              if (stk_empty) begin
                rsp_status_q <= StatusUnderflow;
              end else begin
                rsp_status_q <= StatusOk;
                rsp_data_q   <= stk_data_out;
                // A full stack ignores simultaneous strobes, so split into pop then push.
                if (stk_full) begin
                  state_q     <= StRepPop;
                  rsp_valid_q <= 1'b0;
                end
              end
            end
            OpClear: begin
              clr_cnt_q   <= '0;
              state_q     <= StClear;
              rsp_valid_q <= 1'b0;
            end
            default: rsp_status_q <= StatusIllegal;
          endcase
        end
        StRepPop: state_q <= StRepPush;
        StRepPush: begin
          rsp_status_q <= StatusOk;
          rsp_valid_q  <= 1'b1;
          state_q      <= StResp;
        end
        StClear: begin
          if (stk_empty) begin
            rsp_data_q   <= DATA_WIDTH'(clr_cnt_q);
            rsp_status_q <= StatusOk;
            rsp_valid_q  <= 1'b1;
            state_q      <= StResp;
          end else begin
            clr_cnt_q <= clr_cnt_q + CNT_WIDTH'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_cmd_ctrl.sv
// Directed bench for stack_cmd_ctrl with a DEPTH=4 stack attached.
module tb_stack_cmd_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  localparam logic [2:0] PUSH = 3'd0, POP = 3'd1, PEEK = 3'd2, REPL = 3'd3, CLR = 3'd4;
  localparam logic [1:0] OK = 2'd0, OVF = 2'd1, UNF = 2'd2, ILL = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_status;
  logic          stk_push, stk_pop;
  logic [DW-1:0] stk_data_in, stk_data_out;
  logic          stk_empty, stk_full;

  int checks = 0;
  int errors = 0;
  int push_cnt = 0;
  int pop_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (stk_push) push_cnt <= push_cnt + 1;
    if (stk_pop) pop_cnt <= pop_cnt + 1;
  end

  stack_cmd_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_status   (rsp_status),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .stk_empty    (stk_empty),
    .stk_full     (stk_full)
  );

  stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (stk_push),
    .pop      (stk_pop),
    .data_in  (stk_data_in),
    .data_out (stk_data_out),
    .empty    (stk_empty),
    .full     (stk_full)
  );

  // Handshake one command; returns just after the accepting edge (cycle T+1).
  task automatic issue_cmd(input logic [2:0] op, input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_timeout op=%0d cmd_ready=%b required 1", op, cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
  endtask

  // Full transaction; lat is the cycle offset from handshake at which rsp_valid appears.
  task automatic do_cmd(input logic [2:0] op, input logic [DW-1:0] d, input int hold,
                        output logic [DW-1:0] rdata, output logic [1:0] rstat, output int lat);
    rsp_ready = (hold == 0);
    issue_cmd(op, d);
    @(negedge clk);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_data;
    rstat = rsp_status;
    for (int i = 0; i < hold; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== rdata || rsp_status !== rstat || cmd_ready !== 1'b0)
      begin
        errors++;
        $display("FAIL stall_hold cyc=%0d valid=%b data=%h status=%0d cmd_ready=%b required 1 %h %0d 0",
                 i, rsp_valid, rsp_data, rsp_status, cmd_ready, rdata, rstat);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_status !== OK ||
        stk_push !== 1'b0 || stk_pop !== 1'b0 || stk_empty !== 1'b1) begin
      errors++;
      $display("FAIL reset cmd_ready=%b rsp_valid=%b data=%h status=%0d push=%b pop=%b empty=%b required 1 0 0 0 0 0 1",
               cmd_ready, rsp_valid, rsp_data, rsp_status, stk_push, stk_pop, stk_empty);
    end
  endtask

  task automatic test_push_pop;
    logic [2:0]    ops [6] = '{PUSH, PUSH, PUSH, PEEK, POP, PEEK};
    logic [DW-1:0] din [6] = '{32'hA, 32'hB, 32'hC, 32'h0, 32'h0, 32'h0};
    logic [DW-1:0] exp [6] = '{32'hA, 32'hB, 32'hC, 32'hC, 32'hC, 32'hB};
    logic [DW-1:0] d;
    logic [1:0]    s;
    int            lat;
    for (int i = 0; i < 6; i++) begin
      do_cmd(ops[i], din[i], 0, d, s, lat);
      checks++;
      if (d !== exp[i] || s !== OK || lat !== 2) begin
        errors++;
        $display("FAIL push_pop[%0d] data=%h status=%0d lat=%0d required %h 0 2",
                 i, d, s, lat, exp[i]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [DW-1:0] d;
    logic [1:0]    s;
    int            lat;
    int            p0;
    do_cmd(PUSH, 32'h3, 0, d, s, lat);
    do_cmd(PUSH, 32'h4, 0, d, s, lat);
    checks++;
    if (stk_full !== 1'b1) begin
      errors++;
      $display("FAIL fill_full full=%b required 1", stk_full);
    end
    p0 = push_cnt;
    do_cmd(PUSH, 32'hF, 0, d, s, lat);
    checks++;
    if (s !== OVF || d !== '0 || push_cnt - p0 !== 0 || lat !== 2) begin
      errors++;
      $display("FAIL overflow status=%0d data=%h pushes=%0d lat=%0d required 1 0 0 2",
               s, d, push_cnt - p0, lat);
    end
    do_cmd(PEEK, 32'h0, 0, d, s, lat);
    checks++;
    if (s !== OK || d !== 32'h4) begin
      errors++;
      $display("FAIL overflow_peek status=%0d data=%h required 0 4", s, d);
    end
  endtask

  task automatic test_replace;
    logic [DW-1:0] d;
    logic [1:0]    s;
    int            lat;
    int            p0, q0;
    p0 = push_cnt;
    q0 = pop_cnt;
    do_cmd(REPL, 32'h99, 0, d, s, lat);
    checks++;
    if (s !== OK || d !== 32'h4 || lat !== 4 || push_cnt - p0 !== 1 || pop_cnt - q0 !== 1) begin
      errors++;
      $display("FAIL replace_full status=%0d data=%h lat=%0d pushes=%0d pops=%0d required 0 4 4 1 1",
               s, d, lat, push_cnt - p0, pop_cnt - q0);
    end
    do_cmd(PEEK, 32'h0, 0, d, s, lat);
    checks++;
    if (s !== OK || d !== 32'h99 || stk_full !== 1'b1) begin
      errors++;
      $display("FAIL replace_full_peek status=%0d data=%h full=%b required 0 99 1", s, d, stk_full);
    end
    // Stack now A,B,3,99; pop to 3 entries and replace in place.
    do_cmd(POP, 32'h0, 0, d, s, lat);
    do_cmd(REPL, 32'h77, 0, d, s, lat);
    checks++;
    if (s !== OK || d !== 32'h3 || lat !== 2) begin
      errors++;
      $display("FAIL replace_mid status=%0d data=%h lat=%0d required 0 3 2", s, d, lat);
    end
    do_cmd(PEEK, 32'h0, 0, d, s, lat);
    checks++;
    if (s !== OK || d !== 32'h77) begin
      errors++;
      $display("FAIL replace_mid_peek status=%0d data=%h required 0 77", s, d);
    end
  endtask

  task automatic test_clear;
    logic [DW-1:0] d;
    logic [1:0]    s;
    int            lat;
    int            q0;
    q0 = pop_cnt;
    do_cmd(CLR, 32'h0, 0, d, s, lat);
    checks++;
    if (s !== OK || d !== 32'd3 || lat !== 6 || pop_cnt - q0 !== 3 || stk_empty !== 1'b1) begin
      errors++;
      $display("FAIL clear3 status=%0d data=%h lat=%0d pops=%0d empty=%b required 0 3 6 3 1",
               s, d, lat, pop_cnt - q0, stk_empty);
    end
    q0 = pop_cnt;
    do_cmd(CLR, 32'h0, 0, d, s, lat);
    checks++;
    if (s !== OK || d !== 32'd0 || lat !== 3 || pop_cnt - q0 !== 0) begin
      errors++;
      $display("FAIL clear0 status=%0d data=%h lat=%0d pops=%0d required 0 0 3 0",
               s, d, lat, pop_cnt - q0);
    end
  endtask

  task automatic test_underflow;
    logic [2:0]    ops  [4] = '{POP, PEEK, REPL, 3'd6};
    logic [1:0]    exps [4] = '{UNF, UNF, UNF, ILL};
    logic [DW-1:0] d;
    logic [1:0]    s;
    int            lat;
    int            p0, q0;
    for (int i = 0; i < 4; i++) begin
      p0 = push_cnt;
      q0 = pop_cnt;
      do_cmd(ops[i], 32'h55, 0, d, s, lat);
      checks++;
      if (s !== exps[i] || d !== '0 || lat !== 2 || push_cnt != p0 || pop_cnt != q0) begin
        errors++;
        $display("FAIL underflow[%0d] status=%0d data=%h lat=%0d strobes=%0d required %0d 0 2 0",
                 i, s, d, lat, (push_cnt - p0) + (pop_cnt - q0), exps[i]);
      end
    end
  endtask

  task automatic test_stall;
    logic [DW-1:0] d;
    logic [1:0]    s;
    int            lat;
    do_cmd(PUSH, 32'h5, 0, d, s, lat);
    do_cmd(POP, 32'h0, 5, d, s, lat);
    checks++;
    if (s !== OK || d !== 32'h5 || lat !== 2) begin
      errors++;
      $display("FAIL stall_pop status=%0d data=%h lat=%0d required 0 5 2", s, d, lat);
    end
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release cmd_ready=%b rsp_valid=%b required 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_clear;
    logic [DW-1:0] d;
    logic [1:0]    s;
    int            lat;
    int            q0;
    for (int i = 1; i <= 4; i++) do_cmd(PUSH, DW'(i), 0, d, s, lat);
    q0 = pop_cnt;
    issue_cmd(CLR, 32'h0);
    repeat (4) @(negedge clk);
    checks++;
    if (pop_cnt - q0 !== 2) begin
      errors++;
      $display("FAIL mid_clear_pops pops=%0d required 2", pop_cnt - q0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || stk_empty !== 1'b1 || stk_pop !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear_reset rsp_valid=%b cmd_ready=%b empty=%b pop=%b required 0 1 1 0",
               rsp_valid, cmd_ready, stk_empty, stk_pop);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_cmd(PUSH, 32'h1, 0, d, s, lat);
    do_cmd(PEEK, 32'h0, 0, d, s, lat);
    checks++;
    if (s !== OK || d !== 32'h1 || lat !== 2) begin
      errors++;
      $display("FAIL post_reset_peek status=%0d data=%h lat=%0d required 0 1 2", s, d, lat);
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_replace();
    test_clear();
    test_underflow();
    test_stall();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
